// File: rtl/alu_seq_if.sv
// Command and response handshake bundle between issue logic and the ALU sequencer.
interface alu_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic        cmd_mul;
  logic [3:0]  cmd_cond;
  logic        cmd_s;
  logic [2:0]  cmd_shiftop;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_tag;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_executed;
  logic        rsp_wr;

  modport master (
    output cmd_valid, cmd_op, cmd_mul, cmd_cond, cmd_s, cmd_shiftop, cmd_a, cmd_b, cmd_tag,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_tag, rsp_executed, rsp_wr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mul, cmd_cond, cmd_s, cmd_shiftop, cmd_a, cmd_b, cmd_tag,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_tag, rsp_executed, rsp_wr
  );
endinterface

// File: rtl/alu_seq.sv
// ALU command sequencer: condition check against the NVCZ flag register, single-cycle
// ALU ops or shift-add multiply, registered response with valid/ready handoff.
module alu_seq (
  input  logic        clk,
  input  logic        reset_n,
  alu_seq_if.slave    bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  alu_shiftop,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [2:0]  shiftop_q;
  logic        s_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] acc_q;
  logic        cond_pass;
  logic        is_test;
  logic        mul_last;
  logic        fn, fv, fc, fz;

  assign {fn, fv, fc, fz} = flags;
  assign is_test  = (op_q[3:2] == 2'b10);
  assign mul_last = (b_q[31:1] == '0);

  always_comb begin
    cond_pass = 1'b0;
    unique case (bus.cmd_cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.cmd_valid) begin
        if (!cond_pass)       state_d = RESP;
        else if (bus.cmd_mul) state_d = MUL;
        else                  state_d = EXEC;
      end
      EXEC: state_d = RESP;
      MUL:  if (mul_last) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_ctrl      = '0;
    alu_shiftop   = '0;
    bus.cmd_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    busy          = (state_q != IDLE);
    unique case (state_q)
      EXEC: begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_ctrl    = op_q;
        alu_shiftop = {shiftop_q[2:1], shiftop_q[0] | is_test};
      end
      MUL: begin
        alu_a    = acc_q;
        alu_b    = b_q[0] ? a_q : '0;
        alu_ctrl = 4'b0100;
      end
      default: ;
    endcase
  end

  // a_q/b_q double as the multiplicand (m) and multiplier (q) shift registers in MUL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q             <= '0;
      shiftop_q        <= '0;
      s_q              <= 1'b0;
      a_q              <= '0;
      b_q              <= '0;
      acc_q            <= '0;
      flags            <= '0;
      bus.rsp_result   <= '0;
      bus.rsp_tag      <= '0;
      bus.rsp_executed <= 1'b0;
      bus.rsp_wr       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.cmd_valid) begin
          op_q        <= bus.cmd_op;
          shiftop_q   <= bus.cmd_shiftop;
          s_q         <= bus.cmd_s;
          a_q         <= bus.cmd_a;
          b_q         <= bus.cmd_b;
          acc_q       <= '0;
          bus.rsp_tag <= bus.cmd_tag;
          if (!cond_pass) begin
            bus.rsp_result   <= '0;
            bus.rsp_executed <= 1'b0;
            bus.rsp_wr       <= 1'b0;
          end
        end
        EXEC: begin
          bus.rsp_result   <= alu_result;
          bus.rsp_executed <= 1'b1;
          bus.rsp_wr       <= !is_test;
          if (s_q || is_test) flags <= alu_flags;
        end
        MUL: begin
          acc_q <= alu_result;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          if (mul_last) begin
            bus.rsp_result   <= alu_result;
            bus.rsp_executed <= 1'b1;
            bus.rsp_wr       <= 1'b1;
            if (s_q) begin
              flags[3] <= alu_result[31];
              flags[0] <= (alu_result == '0);
            end
          end
        end
        RESP: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural ALU model on the alu_* side.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl, alu_flags, flags;
  logic [2:0]  alu_shiftop;
  logic        busy;

  alu_seq_if bus();

  alu_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_shiftop (alu_shiftop),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .flags       (flags),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  tag;
    logic        executed;
    logic        wr;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  mflags = 4'b0000;
  logic [3:0]  exec_ctrl;
  logic [2:0]  exec_shiftop;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] ctrl, input logic cin);
    logic [31:0] x, y, r;
    logic        ci, arith, c, v;
    logic [32:0] s;
    x = a; y = b; ci = 1'b0; arith = 1'b1; r = '0;
    case (ctrl)
      4'h0, 4'h8: begin r = a & b;  arith = 1'b0; end
      4'h1, 4'h9: begin r = a ^ b;  arith = 1'b0; end
      4'h2, 4'hA: begin y = ~b; ci = 1'b1; end
      4'h3:       begin x = b; y = ~a; ci = 1'b1; end
      4'h4, 4'hB: begin end
      4'h5:       begin ci = cin; end
      4'h6:       begin y = ~b; ci = cin; end
      4'h7:       begin x = b; y = ~a; ci = cin; end
      4'hC:       begin r = a | b;  arith = 1'b0; end
      4'hD:       begin r = b;      arith = 1'b0; end
      4'hE:       begin r = a & ~b; arith = 1'b0; end
      default:    begin r = ~b;     arith = 1'b0; end
    endcase
    s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    if (arith) begin
      r = s[31:0];
      c = s[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      c = 1'b0;
      v = 1'b0;
    end
    return {r[31], v, c, (r == 32'd0), r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl, flags[1]);

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, v, cy, z;
    {n, v, cy, z} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic issue(input logic [3:0] op, input logic mul, input logic [3:0] cond,
                       input logic s, input logic [2:0] sh, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    exp_t        e;
    logic [35:0] r;
    logic [31:0] prod;
    int unsigned n;
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_before_issue: got %b expected 1", bus.cmd_ready);
    end
    bus.cmd_op = op; bus.cmd_mul = mul; bus.cmd_cond = cond; bus.cmd_s = s;
    bus.cmd_shiftop = sh; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_tag = tag;
    bus.cmd_valid = 1'b1;
    e.tag = tag;
    if (!cond_ok(cond, mflags)) begin
      e.result = '0; e.executed = 1'b0; e.wr = 1'b0; e.lat = 0;
    end else if (mul) begin
      prod = a * b;
      e.result = prod; e.executed = 1'b1; e.wr = 1'b1;
      n = 1;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      e.lat = n;
      if (s) begin
        mflags[3] = prod[31];
        mflags[0] = (prod == 32'd0);
      end
    end else begin
      r = alu_fn(a, b, op, mflags[1]);
      e.result = r[31:0]; e.executed = 1'b1;
      e.wr = !(op inside {[4'd8:4'd11]});
      e.lat = 1;
      if (s || !e.wr) mflags = r[35:32];
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    exec_ctrl = alu_ctrl;
    exec_shiftop = alu_shiftop;
  endtask

  task automatic receive_rsp(input int unsigned hold);
    exp_t        e;
    int unsigned lat;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (bus.rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_timeout: rsp_valid got %b expected 1 within 64 cycles", bus.rsp_valid);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL rsp_unexpected: got response, expected none queued");
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if (lat !== e.lat) begin
      miscompares++; $display("FAIL rsp_latency: got %0d expected %0d", lat, e.lat);
    end
    vectors++;
    if (bus.rsp_result !== e.result) begin
      miscompares++; $display("FAIL rsp_result: got %h expected %h", bus.rsp_result, e.result);
    end
    vectors++;
    if (bus.rsp_tag !== e.tag || bus.rsp_executed !== e.executed || bus.rsp_wr !== e.wr) begin
      miscompares++;
      $display("FAIL rsp_fields: got tag=%h exec=%b wr=%b expected tag=%h exec=%b wr=%b",
               bus.rsp_tag, bus.rsp_executed, bus.rsp_wr, e.tag, e.executed, e.wr);
    end
    vectors++;
    if (flags !== mflags) begin
      miscompares++; $display("FAIL flags: got %b expected %b", flags, mflags);
    end
    vectors++;
    if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_busy: got cmd_ready=%b busy=%b expected 0 1", bus.cmd_ready, busy);
    end
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e.result || bus.cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL rsp_hold: got valid=%b result=%h ready=%b expected 1 %h 0",
                 bus.rsp_valid, bus.rsp_result, bus.cmd_ready, e.result);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL handoff: got valid=%b cmd_ready=%b expected 0 1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_release: got %b expected 1", bus.cmd_ready);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (flags !== 4'b0000 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
        busy !== 1'b0 || alu_ctrl !== 4'b0000 || bus.rsp_result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: got flags=%b ready=%b rv=%b busy=%b ctrl=%b res=%h expected 0000 1 0 0 0000 0",
               flags, bus.cmd_ready, bus.rsp_valid, busy, alu_ctrl, bus.rsp_result);
    end
  endtask

  task automatic test_add_overflow();
    issue(4'b0100, 1'b0, 4'hE, 1'b1, 3'b000, 32'h7FFF_FFFF, 32'd1, 4'h3);
    vectors++;
    if (exec_ctrl !== 4'b0100) begin
      miscompares++; $display("FAIL exec_ctrl_add: got %b expected 0100", exec_ctrl);
    end
    receive_rsp(0);
    vectors++;
    if (flags !== 4'b1100) begin
      miscompares++; $display("FAIL add_flags: got %b expected 1100", flags);
    end
  endtask

  task automatic test_cond();
    issue(4'b1010, 1'b0, 4'hE, 1'b0, 3'b000, 32'd5, 32'd5, 4'h1);
    vectors++;
    if (exec_shiftop[0] !== 1'b1) begin
      miscompares++; $display("FAIL cmp_shiftop0: got %b expected 1", exec_shiftop[0]);
    end
    receive_rsp(0);
    vectors++;
    if (flags !== 4'b0011) begin
      miscompares++; $display("FAIL cmp_flags: got %b expected 0011", flags);
    end
    issue(4'b0100, 1'b0, 4'h0, 1'b0, 3'b000, 32'd1, 32'd1, 4'h2);
    receive_rsp(1);
    issue(4'b0010, 1'b0, 4'h1, 1'b1, 3'b000, 32'd9, 32'd4, 4'h4);
    receive_rsp(0);
    vectors++;
    if (flags !== 4'b0011) begin
      miscompares++; $display("FAIL cond_fail_flags: got %b expected 0011", flags);
    end
  endtask

  task automatic test_mul();
    issue(4'b1010, 1'b0, 4'hE, 1'b0, 3'b000, 32'h8000_0000, 32'd1, 4'h5);
    receive_rsp(0);
    issue(4'b0000, 1'b1, 4'hE, 1'b1, 3'b000, 32'h0001_0000, 32'h0001_0001, 4'h6);
    receive_rsp(0);
    vectors++;
    if (flags !== 4'b0110) begin
      miscompares++; $display("FAIL mul_flags: got %b expected 0110", flags);
    end
    issue(4'b0000, 1'b1, 4'hE, 1'b1, 3'b000, 32'h0000_1234, 32'd0, 4'h7);
    receive_rsp(0);
    vectors++;
    if (flags !== 4'b0111) begin
      miscompares++; $display("FAIL mul_zero_flags: got %b expected 0111", flags);
    end
  endtask

  task automatic test_backpressure();
    issue(4'b1100, 1'b0, 4'hE, 1'b0, 3'b000, 32'h0000_00F0, 32'h0000_000F, 4'h8);
    receive_rsp(5);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [9];
    logic [3:0] op, cond;
    logic       mul, s;
    logic [31:0] a, b;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC};
    for (int i = 0; i < 14; i++) begin
      op   = ops[$urandom_range(0, 8)];
      cond = 4'($urandom_range(0, 15));
      mul  = ($urandom_range(0, 3) == 0);
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = mul ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      issue(op, mul, cond, s, 3'b000, a, b, 4'(i));
      receive_rsp($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    issue(4'b0000, 1'b1, 4'hE, 1'b1, 3'b000, 32'd3, 32'hFFFF_FFFF, 4'h9);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    mflags = 4'b0000;
    vectors++;
    if (flags !== 4'b0000 || busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        alu_ctrl !== 4'b0000 || alu_a !== 32'd0 || bus.rsp_result !== 32'd0 || bus.rsp_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got flags=%b busy=%b rv=%b ready=%b ctrl=%b alu_a=%h res=%h wr=%b",
               flags, busy, bus.rsp_valid, bus.cmd_ready, alu_ctrl, alu_a, bus.rsp_result, bus.rsp_wr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL aborted_rsp: got rsp_valid=1 expected no response");
    end
    issue(4'b0100, 1'b0, 4'hE, 1'b0, 3'b000, 32'd2, 32'd3, 4'hA);
    receive_rsp(0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_mul = 1'b0; bus.cmd_cond = '0;
    bus.cmd_s = 1'b0; bus.cmd_shiftop = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_tag = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_add_overflow();
    test_cond();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
